led_adc_sequencer: RTL and testbench
====================================

// Module: led_adc_sequencer
// PURPOSE
//  Front-end timing stage of the finger-clip channel: alternates RED/IR LEDs at 100 Hz (one LED per half-period),
//  waits for optical settling, runs one ADC conversion per phase over a start/done handshake, and demultiplexes
//  the result into RED_ADC_Value / IR_ADC_Value. Directly feeds FIR_RED (and its IR twin), which clocks on CLK_Filter.
// PARAMETERS
//  PHASE_CYCLES   5000  CLK cycles per LED phase (5 ms at 1 MHz; RED+IR = 10 ms = 100 Hz); must be >= SETTLE_CYCLES+3
//  SETTLE_CYCLES  1000  cycles from phase start until ADC_Start is pulsed; must be >= 1
//  ADC_W          8     ADC sample width
// PORTS
//  CLK            in   1      system clock, all logic on posedge
//  rst_n          in   1      asynchronous active-low reset
//  Enable         in   1      run request; level-sensitive
//  ADC_Done       in   1      one-cycle pulse from ADC, ADC_Data valid in same cycle
//  ADC_Data       in   ADC_W  conversion result
//  LED_RED        out  1      red LED drive
//  LED_IR         out  1      infrared LED drive
//  ADC_Start      out  1      one-cycle conversion request
//  RED_ADC_Value  out  ADC_W  last good red sample (to FIR_RED)
//  IR_ADC_Value   out  ADC_W  last good IR sample
//  RED_Valid      out  1      one-cycle pulse, RED_ADC_Value just updated
//  IR_Valid       out  1      one-cycle pulse, IR_ADC_Value just updated
//  CLK_Filter     out  1      registered filter clock: high for whole IR phase, low otherwise
//  ADC_Err        out  1      sticky: a conversion missed its phase; cleared only by reset
// BEHAVIOUR
//  - Reset (async, immediate, also mid-conversion): state IDLE, phase counter 0; every output 0.
//  - States: IDLE, RED_SETTLE, RED_CONV, IR_SETTLE, IR_CONV. All outputs registered.
//  - IDLE: LEDs off, CLK_Filter 0. Enable=1 seen -> next cycle RED_SETTLE, counter=0.
//  - Phase counter pc runs 0..PHASE_CYCLES-1 in every non-IDLE state, restarts at 0 on phase change.
//  - Break-before-make: both LEDs 0 while pc==0; from pc>=1 only the phase LED is 1. LED_RED & LED_IR never both 1.
//  - *_SETTLE: when pc==SETTLE_CYCLES-1, next cycle ADC_Start=1 (exactly one cycle) and state -> *_CONV.
//  - *_CONV: ADC_Done=1 -> ADC_Data latched into phase's value reg and *_Valid=1 on the following edge (1-cycle
//    latency); state stays *_CONV (no further start) until phase end. Later ADC_Done pulses in the phase ignored.
//  - ADC_Done outside a CONV window with no outstanding start (IDLE, SETTLE, after capture) is ignored.
//  - Timeout: phase ends (pc==PHASE_CYCLES-1) with no ADC_Done -> ADC_Err<=1, value reg holds old value, no Valid.
//  - ADC_Done in the same cycle as pc==PHASE_CYCLES-1 counts as in time (captured, no error).
//  - Phase end: RED_* -> IR_SETTLE, IR_* -> RED_SETTLE if Enable=1, else IDLE (graceful stop, only after IR phase).
//  - CLK_Filter: 1 from first cycle of IR_SETTLE through last IR_CONV cycle; rising edge = RED sample of the
//    just-finished RED phase is stable (>=1 cycle before edge).
//  - Value regs never cleared except by reset; ADC_Data captured exactly, no arithmetic.
// TESTING (PHASE_CYCLES=20, SETTLE_CYCLES=5 unless noted)
//  1 Reset release, Enable=1, ADC model answers 3 cycles after start with 8'hA5 (RED), 8'h3C (IR) -> ADC_Start at
//    pc=5 each phase, RED_ADC_Value=A5 + RED_Valid 1 cycle after Done, IR_ADC_Value=3C, period 40 cycles.
//  2 LED check over 10 frames -> LEDs both 0 at every pc==0, never both 1, CLK_Filter high exactly during IR phases.
//  3 ADC model silent in one RED phase -> ADC_Err=1 at phase end, RED_ADC_Value keeps prior A5, no RED_Valid.
//  4 Spurious ADC_Done with 8'hFF during RED_SETTLE and a second Done after capture -> values unchanged, no Valid.
//  5 Enable dropped mid-RED phase -> IR phase still completes, then IDLE, LEDs/CLK_Filter 0; re-Enable restarts RED.
//  6 rst_n pulsed low mid-IR_CONV -> all outputs 0 asynchronously, ADC_Err cleared, restart from RED_SETTLE.

Source files
------------

// File: rtl/led_adc_sequencer.sv
// Alternating RED/IR LED drive with settle delay, one ADC conversion per phase and per-channel demux.
// CLK_Filter marks the IR phase so the downstream RED filter clocks on a stable sample.
module led_adc_sequencer #(
    parameter int PHASE_CYCLES  = 5000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int ADC_W         = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             Enable,
    input  logic             ADC_Done,
    input  logic [ADC_W-1:0] ADC_Data,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic             ADC_Start,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic             RED_Valid,
    output logic             IR_Valid,
    output logic             CLK_Filter,
    output logic             ADC_Err
);

    localparam int PC_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PC_W-1:0] PC_LAST     = PC_W'(PHASE_CYCLES - 1);
    localparam logic [PC_W-1:0] SETTLE_LAST = PC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RED_SETTLE, RED_CONV, IR_SETTLE, IR_CONV} state_t;

    state_t          st, st_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic            cap, cap_nx;
    logic            in_conv, phase_end, take;
    logic            led_red_d, led_ir_d, start_d, cf_d, red_v_d, ir_v_d, err_d;

    assign in_conv   = (st == RED_CONV) || (st == IR_CONV);
    assign phase_end = (st != IDLE) && (pc == PC_LAST);
    // Only the first Done of a conversion window is taken; later ones in the phase are dropped.
    assign take      = in_conv && !cap && ADC_Done;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            pc            <= '0;
            cap           <= 1'b0;
            LED_RED       <= 1'b0;
            LED_IR        <= 1'b0;
            ADC_Start     <= 1'b0;
            CLK_Filter    <= 1'b0;
            RED_Valid     <= 1'b0;
            IR_Valid      <= 1'b0;
            ADC_Err       <= 1'b0;
            RED_ADC_Value <= '0;
            IR_ADC_Value  <= '0;
        end else begin
            st         <= st_nx;
            pc         <= pc_nx;
            cap        <= cap_nx;
            LED_RED    <= led_red_d;
            LED_IR     <= led_ir_d;
            ADC_Start  <= start_d;
            CLK_Filter <= cf_d;
            RED_Valid  <= red_v_d;
            IR_Valid   <= ir_v_d;
            ADC_Err    <= err_d;
            if (red_v_d) RED_ADC_Value <= ADC_Data;
            if (ir_v_d)  IR_ADC_Value  <= ADC_Data;
        end
    end

    always_comb begin
        st_nx  = st;
        pc_nx  = pc;
        cap_nx = cap;
        case (st)
            IDLE: begin
                pc_nx  = '0;
                cap_nx = 1'b0;
                if (Enable) st_nx = RED_SETTLE;
            end
            RED_SETTLE, IR_SETTLE: begin
                pc_nx = pc + PC_W'(1);
                if (pc == SETTLE_LAST) st_nx = (st == RED_SETTLE) ? RED_CONV : IR_CONV;
            end
            RED_CONV, IR_CONV: begin
                pc_nx = pc + PC_W'(1);
                if (take) cap_nx = 1'b1;
                if (phase_end) begin
                    pc_nx  = '0;
                    cap_nx = 1'b0;
                    if (st == RED_CONV) st_nx = IR_SETTLE;
                    else                st_nx = Enable ? RED_SETTLE : IDLE;
                end
            end
            default: begin
                st_nx  = IDLE;
                pc_nx  = '0;
                cap_nx = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the cycle's pc.
    always_comb begin
        led_red_d = ((st_nx == RED_SETTLE) || (st_nx == RED_CONV)) && (pc_nx != '0);
        led_ir_d  = ((st_nx == IR_SETTLE)  || (st_nx == IR_CONV))  && (pc_nx != '0);
        cf_d      = (st_nx == IR_SETTLE) || (st_nx == IR_CONV);
        start_d   = ((st == RED_SETTLE) || (st == IR_SETTLE)) && (pc == SETTLE_LAST);
        red_v_d   = take && (st == RED_CONV);
        ir_v_d    = take && (st == IR_CONV);
        err_d     = ADC_Err || (in_conv && phase_end && !cap && !ADC_Done);
    end

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed bench for led_adc_sequencer with PHASE_CYCLES=20, SETTLE_CYCLES=5 and a 3-cycle ADC model.
module tb_led_adc_sequencer;
    localparam int P = 20;
    localparam int S = 5;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       Enable = 1'b0;
    logic       ADC_Done;
    logic [7:0] ADC_Data;
    logic       LED_RED, LED_IR, ADC_Start, RED_Valid, IR_Valid, CLK_Filter, ADC_Err;
    logic [7:0] RED_ADC_Value, IR_ADC_Value;

    logic       model_done = 1'b0;
    logic [7:0] model_data = 8'h00;
    int         mcnt = 0;
    logic       m_red = 1'b0;
    logic       adc_silent = 1'b0;
    logic       spur_done = 1'b0;
    logic [7:0] spur_data = 8'h00;

    int total = 0;
    int bad = 0;

    typedef struct {
        int         k;
        logic       lr, li, st, cf, rv, iv, er;
        logic [7:0] rval, ival;
    } vec_t;
    vec_t tbl[$];

    led_adc_sequencer #(.PHASE_CYCLES(P), .SETTLE_CYCLES(S), .ADC_W(8)) dut (
        .CLK(CLK), .rst_n(rst_n), .Enable(Enable), .ADC_Done(ADC_Done), .ADC_Data(ADC_Data),
        .LED_RED(LED_RED), .LED_IR(LED_IR), .ADC_Start(ADC_Start),
        .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
        .RED_Valid(RED_Valid), .IR_Valid(IR_Valid), .CLK_Filter(CLK_Filter), .ADC_Err(ADC_Err)
    );

    always #5 CLK = ~CLK;

    assign ADC_Done = model_done | spur_done;
    assign ADC_Data = spur_done ? spur_data : model_data;

    // ADC answers 3 cycles after the start cycle: A5 for a red conversion, 3C for IR.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            mcnt       <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (ADC_Start && !adc_silent) begin
                mcnt  <= 2;
                m_red <= LED_RED;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    model_done <= 1'b1;
                    model_data <= m_red ? 8'hA5 : 8'h3C;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [22:0] outs();
        return {LED_RED, LED_IR, ADC_Start, CLK_Filter, RED_Valid, IR_Valid, ADC_Err,
                RED_ADC_Value, IR_ADC_Value};
    endfunction

    initial begin
        int   ti;
        int   ph, pcx;
        logic seen;
        logic [22:0] ev;

        //             k   lr li st cf rv iv er  red    ir
        tbl.push_back('{ 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{ 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{ 4, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{ 5, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{ 6, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{ 8, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00});
        tbl.push_back('{ 9, 1, 0, 0, 0, 1, 0, 0, 8'hA5, 8'h00});
        tbl.push_back('{10, 1, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h00});
        tbl.push_back('{19, 1, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h00});
        tbl.push_back('{20, 0, 0, 0, 1, 0, 0, 0, 8'hA5, 8'h00});
        tbl.push_back('{21, 0, 1, 0, 1, 0, 0, 0, 8'hA5, 8'h00});
        tbl.push_back('{25, 0, 1, 1, 1, 0, 0, 0, 8'hA5, 8'h00});
        tbl.push_back('{28, 0, 1, 0, 1, 0, 0, 0, 8'hA5, 8'h00});
        tbl.push_back('{29, 0, 1, 0, 1, 0, 1, 0, 8'hA5, 8'h3C});
        tbl.push_back('{39, 0, 1, 0, 1, 0, 0, 0, 8'hA5, 8'h3C});
        tbl.push_back('{40, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h3C});
        tbl.push_back('{45, 1, 0, 1, 0, 0, 0, 0, 8'hA5, 8'h3C});
        tbl.push_back('{49, 1, 0, 0, 0, 1, 0, 0, 8'hA5, 8'h3C});

        Enable = 1'b1;
        cyc(2);
        chk("reset_outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        cyc(1);

        // Ten frames: table records for the first two, timing formula on every cycle.
        ti = 0;
        for (int k = 0; k < 10 * 2 * P; k++) begin
            if (ti < tbl.size() && tbl[ti].k == k) begin
                ev = {tbl[ti].lr, tbl[ti].li, tbl[ti].st, tbl[ti].cf, tbl[ti].rv, tbl[ti].iv,
                      tbl[ti].er, tbl[ti].rval, tbl[ti].ival};
                chk($sformatf("vec_k%0d", k), 32'(outs()), 32'(ev));
                ti++;
            end
            ph  = (k / P) % 2;
            pcx = k % P;
            chk($sformatf("frame_k%0d", k),
                32'({LED_RED, LED_IR, ADC_Start, CLK_Filter, RED_Valid, IR_Valid, ADC_Err}),
                32'({ph == 0 && pcx != 0, ph == 1 && pcx != 0, pcx == S, ph == 1,
                     ph == 0 && pcx == 9, ph == 1 && pcx == 9, 1'b0}));
            cyc(1);
        end

        // Done on the last cycle of the RED phase is still in time.
        adc_silent = 1'b1;
        cyc(19);
        spur_done = 1'b1;
        spur_data = 8'h77;
        cyc(1);
        spur_done  = 1'b0;
        adc_silent = 1'b0;
        chk("late_done_value", 32'(RED_ADC_Value), 32'h77);
        chk("late_done_valid", 32'(RED_Valid), 32'h1);
        chk("late_done_no_err", 32'(ADC_Err), 32'h0);
        cyc(20);

        // Silent RED phase: error at phase end, value held, no valid.
        adc_silent = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < P; i++) begin
            seen = seen | RED_Valid;
            if (i == P - 1) chk("err_before_end", 32'(ADC_Err), 32'h0);
            cyc(1);
        end
        adc_silent = 1'b0;
        chk("timeout_no_valid", 32'(seen), 32'h0);
        chk("timeout_err", 32'(ADC_Err), 32'h1);
        chk("timeout_hold", 32'(RED_ADC_Value), 32'h77);
        cyc(20);
        chk("err_sticky", 32'(ADC_Err), 32'h1);

        // Spurious Done in RED_SETTLE and after capture.
        cyc(2);
        spur_done = 1'b1;
        spur_data = 8'hFF;
        cyc(1);
        spur_done = 1'b0;
        chk("spur_settle", 32'({RED_Valid, RED_ADC_Value}), 32'({1'b0, 8'h77}));
        cyc(6);
        chk("capture_after_spur", 32'({RED_Valid, RED_ADC_Value}), 32'({1'b1, 8'hA5}));
        cyc(3);
        spur_done = 1'b1;
        cyc(1);
        spur_done = 1'b0;
        chk("spur_after_cap", 32'({RED_Valid, IR_Valid, RED_ADC_Value}), 32'({2'b00, 8'hA5}));

        // Enable dropped mid-RED: IR phase still runs, then idle.
        cyc(37);
        Enable = 1'b0;
        cyc(19);
        chk("stop_ir_capture", 32'({IR_Valid, IR_ADC_Value}), 32'({1'b1, 8'h3C}));
        cyc(10);
        chk("stop_ir_last", 32'({LED_IR, CLK_Filter}), 32'h3);
        cyc(1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | LED_RED | LED_IR | CLK_Filter | ADC_Start;
            cyc(1);
        end
        chk("idle_quiet", 32'(seen), 32'h0);
        Enable = 1'b1;
        cyc(1);
        chk("restart_pc0", 32'({LED_RED, LED_IR, CLK_Filter}), 32'h0);
        cyc(1);
        chk("restart_red_on", 32'(LED_RED), 32'h1);
        cyc(4);
        chk("restart_start", 32'(ADC_Start), 32'h1);

        // Async reset in the middle of IR_CONV.
        cyc(22);
        chk("pre_reset_state", 32'({LED_IR, CLK_Filter, ADC_Err}), 32'h7);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("post_reset_k0", 32'(outs()), 32'h0);
        cyc(1);
        chk("post_reset_k1", 32'(LED_RED), 32'h1);
        cyc(4);
        chk("post_reset_start", 32'(ADC_Start), 32'h1);
        cyc(4);
        chk("post_reset_capture", 32'({RED_Valid, ADC_Err, RED_ADC_Value}), 32'({2'b10, 8'hA5}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
